// File: rtl/ysyx_22050612_mdu_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide unit.
interface ysyx_22050612_mdu_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_22050612_mdu.sv
// Iterative RV64M/RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// operands handled as magnitudes with the sign fixed up on the last step.
module ysyx_22050612_mdu #(
    parameter int unsigned XLEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    ysyx_22050612_mdu_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,  OP_MULH  = 4'd1,  OP_MULHSU = 4'd2,  OP_MULHU = 4'd3,
        OP_DIV    = 4'd4,  OP_DIVU  = 4'd5,  OP_REM    = 4'd6,  OP_REMU  = 4'd7,
        OP_MULW   = 4'd8,  OP_RSV9  = 4'd9,  OP_RSV10  = 4'd10, OP_RSV11 = 4'd11,
        OP_DIVW   = 4'd12, OP_DIVUW = 4'd13, OP_REMW   = 4'd14, OP_REMUW = 4'd15
    } op_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    op_e               op_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    op_e               op_in;
    logic              is_w, reserved, is_div, is_rem;
    logic              sgn1, sgn2, neg1, neg2, neg_init;
    logic              div_zero, overflow, special;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_v, special_val;
    logic [2*XLEN-1:0] acc_init;

    always_comb begin
        op_in    = op_e'(bus.op);
        is_w     = (XLEN == 64) && bus.op[3];
        reserved = (bus.op inside {4'd9, 4'd10, 4'd11}) || ((XLEN == 32) && bus.op[3]);
        is_div   = bus.op[2];
        is_rem   = bus.op[2] && bus.op[1];
        sgn1     = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sgn2     = op_in inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};

        a_ext = bus.src1;
        b_ext = bus.src2;
        if (is_w) begin
            if (op_in inside {OP_DIVUW, OP_REMUW}) begin
                a_ext = zext32(bus.src1[31:0]);
                b_ext = zext32(bus.src2[31:0]);
            end else begin
                a_ext = sext32(bus.src1[31:0]);
                b_ext = sext32(bus.src2[31:0]);
            end
        end

        neg1  = sgn1 && a_ext[XLEN-1];
        neg2  = sgn2 && b_ext[XLEN-1];
        a_abs = neg1 ? ('0 - a_ext) : a_ext;
        b_abs = neg2 ? ('0 - b_ext) : b_ext;

        // W overflow is judged on the 32-bit view, i.e. the sign-extended 0x80000000
        min_v          = '0;
        min_v[XLEN-1]  = 1'b1;
        if (is_w) min_v = sext32(32'h8000_0000);

        div_zero = (b_ext == '0);
        overflow = (op_in inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW}) &&
                   (a_ext == min_v) && (b_ext == '1);
        special  = reserved || (is_div && (div_zero || overflow));

        special_val = '0;
        if (reserved) begin
            special_val = '0;
        end else if (is_div && div_zero) begin
            if (!is_rem)   special_val = '1;
            else if (is_w) special_val = sext32(bus.src1[31:0]);
            else           special_val = bus.src1;
        end else if (is_div && overflow) begin
            if (is_rem) special_val = '0;
            else        special_val = a_ext;
        end

        neg_init = is_rem ? neg1 : (neg1 ^ neg2);

        if (special)     acc_init = {{XLEN{1'b0}}, special_val};
        else if (is_div) acc_init = {{XLEN{1'b0}}, a_abs};
        else             acc_init = {{XLEN{1'b0}}, b_abs};
    end

    logic [XLEN:0]     rem_sh, diff, sum;
    logic [2*XLEN-1:0] acc_d, prod;
    logic [XLEN-1:0]   sel, result_d;

    // acc_q holds {remainder, quotient} when dividing and {partial product, multiplier} when multiplying
    always_comb begin
        rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        if (op_q[2]) begin
            if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_d = {sum, acc_q[XLEN-1:1]};
        end

        prod = neg_q ? ('0 - acc_d) : acc_d;

        if (op_q[2]) begin
            sel = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
            if (neg_q) sel = '0 - sel;
        end else if ((op_q == OP_MUL) || (op_q == OP_MULW)) begin
            sel = prod[XLEN-1:0];
        end else begin
            sel = prod[2*XLEN-1:XLEN];
        end

        result_d = ((XLEN == 64) && op_q[3]) ? sext32(sel[31:0]) : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q      <= op_in;
                        neg_q     <= neg_init;
                        special_q <= special;
                        opnd_q    <= is_div ? b_abs : a_abs;
                        acc_q     <= acc_init;
                        cnt_q     <= CW'(XLEN);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (special_q) begin
                        result_q    <= acc_q[XLEN-1:0];
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == CW'(1)) begin
                            result_q    <= result_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: doc/ysyx_22050612_mdu.md
# ysyx_22050612_mdu

Multi-cycle RV64M/RV32M multiply/divide unit. It sits beside the single-cycle execute datapath and takes the M-extension opcodes that cannot finish in one cycle. Operands come in and results go out over valid/ready handshakes. It uses an iterative one-bit-per-cycle shift-add multiplier and restoring divider, parametrised in operand width, with a flush input for pipeline redirects.

## Interface
Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  abort the current operation and discard any held result.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  4  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; 9–11 reserved.
- src1  in  XLEN  rs1 value (multiplicand/dividend).
- src2  in  XLEN  rs2 value (multiplier/divisor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  result; held stable while out_valid && !out_ready.

## Operation
- States are IDLE, BUSY and DONE. Reset gives IDLE with in_ready=1, out_valid=0, result=0 and the iteration counter=0.
- Acceptance happens on an edge with in_valid && in_ready && !flush.
  - op, the operand sign flags and the operand absolute values are latched.
  - The counter is loaded with XLEN.
  - The next state is BUSY.
- W ops (8, 12–15), XLEN=64:
  - Operands are first reduced to bits [31:0].
  - They are sign-extended (MULW, DIVW, REMW) or zero-extended (DIVUW, REMUW) to 64.
  - The final 32-bit result is sign-extended to 64.
- W ops and reserved codes, XLEN=32: treated as reserved.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
- Signed ops run the iteration on absolute values, then correct the sign in the final step:
  - A product is negated if the operand signs differ.
  - A quotient is negated if the signs differ.
  - A remainder takes the sign of the dividend.
- Multiply: each BUSY edge conditionally adds the shifted multiplicand into a 2·XLEN accumulator.
  - MUL and MULW take the low half; MULW uses bits [31:0] only.
  - MULH, MULHSU and MULHU take the high half.
- Divide: each BUSY edge performs one restoring shift/subtract step and produces one quotient bit.
- Special cases skip BUSY and go straight to DONE on the edge after acceptance:
  - Divisor = 0: quotient = all ones (W: 0xFFFFFFFF sign-extended), remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = −1): quotient = dividend, remainder = 0.
  - Reserved op: result = 0.
- BUSY: the counter decrements each edge. On the edge where the counter is 1, the sign correction and result selection are applied, result is registered, and the state moves to DONE.
- DONE: out_valid=1. The edge with out_ready=1 returns the state to IDLE with out_valid=0; result keeps its last value.
- No overlap: in_ready=0 in both BUSY and DONE.

## Timing
- Normal op: if acceptance is on edge E, the edges E+1..E+XLEN perform the iterations, and out_valid is first high in the cycle after edge E+XLEN. That is 64 cycles from the acceptance cycle for XLEN=64.
- Special case or reserved op: out_valid is high in the cycle after edge E+1.
- If out_valid && out_ready, the earliest new acceptance is on the following edge (in_ready rises after the DONE→IDLE edge). Throughput is one op per XLEN+2 cycles.
- flush is sampled on the edge, in any state, and forces IDLE with out_valid=0 on that edge. An in_valid in the same cycle is not accepted. An output handshake in the same cycle as a flush is discarded.
- Priority is rst > flush > handshake/iteration.
- rst asserted mid-BUSY: the outputs return to reset values on that edge and no result is produced.
- result and out_valid come straight from registers, with no combinational path from inputs. in_ready is a function of state only.

## Test plan
- XLEN=64, MUL with src1=7, src2=−3 → after 64 cycles out_valid=1, result=0xFFFFFFFFFFFFFFEB. Hold out_ready=0 for 5 cycles: result stays stable and in_ready stays 0.
- MULHU with src1=src2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULH with the same operands → 0. MULHSU with src1=−1, src2=2 → 0xFFFFFFFFFFFFFFFF.
- DIV with −7/2 → −3. REM with −7/2 → −1. DIVU with 0x8000000000000000/0 → all ones, valid after 1 cycle. REM with 0x8000000000000000/−1 → 0.
- DIVW with src1=0x00000000_80000000, src2=0xFFFFFFFF_FFFFFFFF → 0xFFFFFFFF80000000. MULW with 0x7FFFFFFF×2 → 0xFFFFFFFFFFFFFFFE.
- Flush asserted at iteration 30 while in_valid is high → IDLE next cycle, out_valid never rises, and a new op accepted afterwards completes correctly. rst pulsed mid-BUSY → in_ready=1, out_valid=0, result=0.
- Back-to-back random ops (≥10k) with random out_ready stalls, checked against a reference model, for both XLEN=64 and XLEN=32. With XLEN=32, op 8 → result 0 after 1 cycle.
